// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus observer: decodes START/Sr/STOP, data bytes and ACK bits
// from the resolved scl/sda lines and buffers the bytes in a show-ahead FIFO.
// It also flags scl being held low for too long while the bus is busy.
// The module only observes the bus and has no outputs onto it.
module i2c_bus_monitor #(
  parameter int FILT_LEN    = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int STRETCH_MAX = 5000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       ev_valid_o,
  input  logic       ev_ready_i,
  output logic [7:0] ev_data_o,
  output logic       ev_ack_o,
  output logic       ev_first_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       bus_busy_o,
  output logic       stretch_o,
  output logic       overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]  FILT_LAST   = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      STRETCH_LIM = 16'(STRETCH_MAX);

  typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

  logic            scl_s1, scl_s2, sda_s1, sda_s2;
  logic            scl_f, sda_f, scl_prev, sda_prev;
  logic [FC_W-1:0] scl_cnt, sda_cnt;
  logic            scl_rise, start_det, stop_det;

  state_t          state;
  logic [2:0]      bitcnt;
  logic [7:0]      sr;
  logic            first;
  logic            push;
  logic [9:0]      push_data;

  logic [15:0]     stretch_cnt;

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, accepted;

  // Synchronise both lines and only follow a new level after FILT_LEN
  // consecutive samples disagree with the filtered one; idle-high reset
  // values keep reset release from looking like a START.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      scl_s1   <= scl_i;
      scl_s2   <= scl_s1;
      sda_s1   <= sda_i;
      sda_s2   <= sda_s1;
      scl_prev <= scl_f;
      sda_prev <= sda_f;
      if (scl_s2 != scl_f) begin
        if (scl_cnt == FILT_LAST) begin
          scl_f   <= scl_s2;
          scl_cnt <= '0;
        end else begin
          scl_cnt <= scl_cnt + 1'b1;
        end
      end else begin
        scl_cnt <= '0;
      end
      if (sda_s2 != sda_f) begin
        if (sda_cnt == FILT_LAST) begin
          sda_f   <= sda_s2;
          sda_cnt <= '0;
        end else begin
          sda_cnt <= sda_cnt + 1'b1;
        end
      end else begin
        sda_cnt <= '0;
      end
    end
  end

  // Bus conditions need scl steady high across the sda edge, so a cycle in
  // which scl also moves never counts as START or STOP.
  assign scl_rise  = scl_f & ~scl_prev;
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

  // Bit/byte decoder with registered condition pulses, busy flag and push request.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      bitcnt     <= '0;
      sr         <= '0;
      first      <= 1'b0;
      push       <= 1'b0;
      push_data  <= '0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      bus_busy_o <= 1'b0;
    end else begin
      start_o <= start_det;
      stop_o  <= stop_det;
      push    <= 1'b0;
      if (start_det) begin
        bus_busy_o <= 1'b1;
      end else if (stop_det) begin
        bus_busy_o <= 1'b0;
      end
      if (stop_det) begin
        state  <= IDLE;
        bitcnt <= '0;
      end else if (start_det) begin
        state  <= BITS;
        bitcnt <= '0;
        first  <= 1'b1;
      end else if (scl_rise) begin
        case (state)
          BITS: begin
            sr     <= {sr[6:0], sda_f};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) begin
              state <= ACK;
            end
          end
          ACK: begin
            push      <= 1'b1;
            push_data <= {first, sda_f, sr};
            first     <= 1'b0;
            bitcnt    <= '0;
            state     <= BITS;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Saturating count of busy cycles with scl held low.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stretch_cnt <= '0;
    end else if (stop_det || scl_f) begin
      stretch_cnt <= '0;
    end else if (bus_busy_o && stretch_cnt != 16'hFFFF) begin
      stretch_cnt <= stretch_cnt + 16'd1;
    end
  end

  assign stretch_o = (stretch_cnt >= STRETCH_LIM);

  assign full     = (count == FIFO_FULL);
  assign pop      = ev_valid_o & ev_ready_i;
  assign accepted = push & (~full | pop);

  // Show-ahead event FIFO; a push into a full FIFO survives only if the
  // head is popped in the same cycle, otherwise it is dropped and noted.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (accepted) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(accepted) - CNT_W'(pop);
      if (push && !accepted) begin
        overflow_o <= 1'b1;
      end
    end
  end

  assign ev_valid_o = (count != '0);
  assign ev_first_o = mem[rd_ptr][9];
  assign ev_ack_o   = mem[rd_ptr][8];
  assign ev_data_o  = mem[rd_ptr][7:0];

endmodule
